// File: rtl/coeff_load_ctrl_pkg.sv
// Shared constants, state encoding and count helper for the coefficient load controller.
package coeff_load_ctrl_pkg;

    localparam int DATA_W    = 16;
    localparam int ADDR_W    = 6;
    localparam int MAX_COEFF = 64;
    localparam int CNT_W     = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Requests larger than the coefficient memory are trimmed to its size.
    function automatic logic [CNT_W-1:0] clamp_count(input logic [CNT_W-1:0] n);
        logic [CNT_W-1:0] res;
        if (n > CNT_W'(MAX_COEFF)) begin
            res = CNT_W'(MAX_COEFF);
        end else begin
            res = n;
        end
        return res;
    endfunction

endpackage

// File: rtl/coeff_load_ctrl.sv
// Coefficient load controller: takes a counted burst of coefficients over a
// valid/ready handshake and writes them to ascending flat bank addresses.
module coeff_load_ctrl #(
    parameter int DATA_W = coeff_load_ctrl_pkg::DATA_W,
    parameter int ADDR_W = coeff_load_ctrl_pkg::ADDR_W
) (
    input  logic                                iClk,
    input  logic                                iRsn,
    input  logic                                iStart,
    input  logic [coeff_load_ctrl_pkg::CNT_W-1:0] iNumCoeff,
    input  logic                                iCoeffValid,
    input  logic [DATA_W-1:0]                   iCoeff,
    output logic                                oCoeffReady,
    output logic                                oCsn,
    output logic                                oWrn,
    output logic [ADDR_W-1:0]                   oAddr,
    output logic [DATA_W-1:0]                   oWrDt,
    output logic                                oBusy,
    output logic                                oDone
);

    import coeff_load_ctrl_pkg::*;

    localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(MAX_COEFF - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wr_dt_q, wr_dt_d;
    logic               ready_q, ready_d;
    logic               csn_q, csn_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               hs_s;
    logic               last_s;
    logic [CNT_W-1:0]   start_cnt_s;

    assign hs_s        = (state_q == ST_WAIT) & iCoeffValid;
    assign start_cnt_s = clamp_count(iNumCoeff);
    // The top-address term keeps the counter from ever wrapping.
    assign last_s      = (CNT_W'(addr_q) == (cnt_q - 7'd1)) | (addr_q == ADDR_MAX);

    // Next-state, counter and data-capture logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wr_dt_d = wr_dt_q;
        case (state_q)
            ST_IDLE: begin
                if (iStart) begin
                    cnt_d  = start_cnt_s;
                    addr_d = '0;
                    if (start_cnt_s == 7'd0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (hs_s) begin
                    wr_dt_d = iCoeff;
                    state_d = ST_WRITE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WRITE: begin
                if (last_s) begin
                    state_d = ST_DONE;
                end else begin
                    addr_d  = addr_q + 6'd1;
                    state_d = ST_WAIT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they line up with it once registered.
    always_comb begin
        ready_d = 1'b0;
        csn_d   = 1'b1;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_d)
            ST_IDLE: begin
                busy_d = 1'b0;
            end
            ST_WAIT: begin
                ready_d = 1'b1;
                busy_d  = 1'b1;
            end
            ST_WRITE: begin
                csn_d  = 1'b0;
                busy_d = 1'b1;
            end
            ST_DONE: begin
                done_d = 1'b1;
                busy_d = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge iClk) begin
        if (!iRsn) begin
            state_q <= ST_IDLE;
            cnt_q   <= 7'd0;
            addr_q  <= '0;
            wr_dt_q <= '0;
            ready_q <= 1'b0;
            csn_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wr_dt_q <= wr_dt_d;
            ready_q <= ready_d;
            csn_q   <= csn_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Chip select and write enable share one register so they can never differ.
    assign oCoeffReady = ready_q;
    assign oCsn        = csn_q;
    assign oWrn        = csn_q;
    assign oAddr       = addr_q;
    assign oWrDt       = wr_dt_q;
    assign oBusy       = busy_q;
    assign oDone       = done_q;

endmodule

// File: tb/tb_coeff_load_ctrl.sv
// Scoreboard bench for coeff_load_ctrl: expected writes are queued at start and
// matched against every write strobe seen on the bank interface.
module tb_coeff_load_ctrl;

    localparam int DW = 16;
    localparam int AW = 6;

    logic          iClk = 1'b0;
    logic          iRsn;
    logic          iStart;
    logic [6:0]    iNumCoeff;
    logic          iCoeffValid;
    logic [DW-1:0] iCoeff;
    logic          oCoeffReady;
    logic          oCsn;
    logic          oWrn;
    logic [AW-1:0] oAddr;
    logic [DW-1:0] oWrDt;
    logic          oBusy;
    logic          oDone;

    coeff_load_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .iClk        (iClk),
        .iRsn        (iRsn),
        .iStart      (iStart),
        .iNumCoeff   (iNumCoeff),
        .iCoeffValid (iCoeffValid),
        .iCoeff      (iCoeff),
        .oCoeffReady (oCoeffReady),
        .oCsn        (oCsn),
        .oWrn        (oWrn),
        .oAddr       (oAddr),
        .oWrDt       (oWrDt),
        .oBusy       (oBusy),
        .oDone       (oDone)
    );

    always #5 iClk = ~iClk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t           exp_q[$];
    wr_t           mon_w;
    logic [DW-1:0] coeffs [64];
    int            n_checks = 0;
    int            n_pass   = 0;
    int            cyc      = 0;
    int            last_strobe = 0;
    bit            have_last = 1'b0;
    bit            dense     = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] obs_v, input logic [31:0] exp_v);
        n_checks++;
        if (obs_v === exp_v) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs_v, exp_v, $time);
        end
    endtask

    // Bank-side monitor: every strobe must match the head of the scoreboard.
    always @(negedge iClk) begin
        cyc++;
        check_val("csn_eq_wrn", 32'(oWrn), 32'(oCsn));
        if (!oCsn) begin
            check_val("ready_during_strobe", 32'(oCoeffReady), 32'd0);
            if (exp_q.size() == 0) begin
                check_val("unexpected_strobe", 32'(oAddr), 32'hFFFF_FFFF);
            end else begin
                mon_w = exp_q.pop_front();
                check_val("wr_addr", 32'(oAddr), 32'(mon_w.addr));
                check_val("wr_data", 32'(oWrDt), 32'(mon_w.data));
                if (dense && have_last) begin
                    check_val("strobe_gap", 32'(cyc - last_strobe), 32'd2);
                end
            end
            last_strobe = cyc;
            have_last   = 1'b1;
        end
        if (oDone && have_last) begin
            check_val("done_latency", 32'(cyc - last_strobe), 32'd1);
        end
    end

    task automatic start_seq(input int n);
        int m;
        m = (n > 64) ? 64 : n;
        have_last = 1'b0;
        for (int i = 0; i < m; i++) begin
            exp_q.push_back('{addr: AW'(i), data: coeffs[i]});
        end
        iNumCoeff = 7'(n);
        iStart    = 1'b1;
        @(negedge iClk);
        iStart    = 1'b0;
    endtask

    // Present one coefficient, holding valid until the handshake edge has passed.
    task automatic send(input logic [DW-1:0] d, input int gap);
        if (gap > 0) begin
            iCoeffValid = 1'b0;
            repeat (gap) @(negedge iClk);
        end
        iCoeff      = d;
        iCoeffValid = 1'b1;
        for (int k = 0; k < 50 && !oCoeffReady; k++) @(negedge iClk);
        if (!oCoeffReady) check_val("ready_timeout", 32'(oCoeffReady), 32'd1);
        @(negedge iClk);
    endtask

    task automatic feed(input int first, input int last, input int gap_max);
        for (int i = first; i <= last; i++) begin
            send(coeffs[i], (gap_max == 0) ? 0 : int'($urandom_range(0, gap_max)));
        end
        iCoeffValid = 1'b0;
    endtask

    task automatic wait_done(input int exp_addr);
        for (int k = 0; k < 300 && !oDone; k++) @(negedge iClk);
        if (!oDone) begin
            check_val("done_timeout", 32'(oDone), 32'd1);
        end else begin
            check_val("busy_at_done", 32'(oBusy), 32'd1);
            check_val("addr_at_done", 32'(oAddr), 32'(exp_addr));
            check_val("sb_empty", 32'(exp_q.size()), 32'd0);
            @(negedge iClk);
            check_val("done_one_cycle", 32'(oDone), 32'd0);
            check_val("busy_after_done", 32'(oBusy), 32'd0);
            check_val("addr_hold", 32'(oAddr), 32'(exp_addr));
        end
    endtask

    initial begin
        iRsn = 1'b0; iStart = 1'b0; iNumCoeff = 7'd0; iCoeffValid = 1'b0; iCoeff = '0;
        repeat (3) @(negedge iClk);
        check_val("rst_csn", 32'(oCsn), 32'd1);
        check_val("rst_wrn", 32'(oWrn), 32'd1);
        check_val("rst_addr", 32'(oAddr), 32'd0);
        check_val("rst_wrdt", 32'(oWrDt), 32'd0);
        check_val("rst_ready", 32'(oCoeffReady), 32'd0);
        check_val("rst_busy", 32'(oBusy), 32'd0);
        check_val("rst_done", 32'(oDone), 32'd0);
        iRsn = 1'b1;
        @(negedge iClk);

        // Four coefficients, valid held high.
        dense = 1'b1;
        for (int i = 0; i < 64; i++) coeffs[i] = DW'(i + 1);
        start_seq(4);
        check_val("busy_after_start", 32'(oBusy), 32'd1);
        check_val("ready_after_start", 32'(oCoeffReady), 32'd1);
        feed(0, 3, 0);
        wait_done(3);

        // Full 64-entry ramp across all banks.
        for (int i = 0; i < 64; i++) coeffs[i] = DW'(i);
        start_seq(64);
        feed(0, 63, 0);
        wait_done(63);
        check_val("last_bank", 32'(oAddr[5:4]), 32'd3);

        // Oversized request trims to 64; extra valid data must not be taken.
        for (int i = 0; i < 64; i++) coeffs[i] = DW'(16'h8000 + 16'(i * 3));
        start_seq(100);
        feed(0, 63, 0);
        wait_done(63);
        iCoeff = 16'hDEAD; iCoeffValid = 1'b1;
        repeat (4) begin
            @(negedge iClk);
            check_val("no_ready_when_idle", 32'(oCoeffReady), 32'd0);
        end
        iCoeffValid = 1'b0;

        // Zero-length request finishes straight away.
        start_seq(0);
        check_val("zero_done", 32'(oDone), 32'd1);
        check_val("zero_busy", 32'(oBusy), 32'd1);
        wait_done(0);

        // Random valid gaps.
        dense = 1'b0;
        for (int i = 0; i < 64; i++) coeffs[i] = DW'($urandom);
        start_seq(8);
        feed(0, 7, 5);
        wait_done(7);

        // Start pulse while waiting at address 2 is ignored.
        for (int i = 0; i < 64; i++) coeffs[i] = DW'(16'h0A00 + 16'(i));
        start_seq(6);
        feed(0, 1, 0);
        @(negedge iClk);
        check_val("wait_addr2", 32'(oAddr), 32'd2);
        check_val("wait_ready", 32'(oCoeffReady), 32'd1);
        iNumCoeff = 7'd3; iStart = 1'b1;
        @(negedge iClk);
        iStart = 1'b0;
        check_val("start_ignored_busy", 32'(oBusy), 32'd1);
        check_val("start_ignored_addr", 32'(oAddr), 32'd2);
        feed(2, 5, 0);
        wait_done(5);

        // Reset during the write at address 5, with start asserted alongside.
        dense = 1'b1;
        for (int i = 0; i < 64; i++) coeffs[i] = DW'(16'h5500 + 16'(i));
        start_seq(10);
        for (int i = 0; i < 6; i++) send(coeffs[i], 0);
        check_val("pre_rst_strobe", 32'(oCsn), 32'd0);
        check_val("pre_rst_addr", 32'(oAddr), 32'd5);
        iRsn = 1'b0; iStart = 1'b1; iNumCoeff = 7'd9; iCoeffValid = 1'b0;
        @(negedge iClk);
        check_val("abort_csn", 32'(oCsn), 32'd1);
        check_val("abort_wrn", 32'(oWrn), 32'd1);
        check_val("abort_busy", 32'(oBusy), 32'd0);
        check_val("abort_addr", 32'(oAddr), 32'd0);
        check_val("abort_ready", 32'(oCoeffReady), 32'd0);
        exp_q.delete();
        iRsn = 1'b1; iStart = 1'b0;
        @(negedge iClk);
        check_val("rst_beats_start", 32'(oBusy), 32'd0);
        for (int i = 0; i < 64; i++) coeffs[i] = DW'(16'hC0DE - 16'(i));
        start_seq(3);
        check_val("restart_addr", 32'(oAddr), 32'd0);
        feed(0, 2, 0);
        wait_done(2);

        repeat (2) @(negedge iClk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/coeff_load_ctrl.md
COEFF_LOAD_CTRL -- requirements
Module: coeff_load_ctrl

Interface
REQ-001 Parameter: DATA_W, default 16, coefficient width.
REQ-002 Parameter: ADDR_W, default 6, flat coefficient address width; 64 locations across 4 banks of 16.
REQ-003 Port: iClk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port: iRsn  input  1  reset; synchronous, active-low.
REQ-005 Port: iStart  input  1  one-cycle request to begin a load sequence.
REQ-006 Port: iNumCoeff  input  7  number of coefficients to write, sampled at accepted start.
REQ-007 Port: iCoeffValid  input  1  upstream coefficient valid.
REQ-008 Port: iCoeff  input  DATA_W  upstream coefficient, signed two's complement.
REQ-009 Port: oCoeffReady  output  1  block can accept a coefficient this cycle.
REQ-010 Port: oCsn  output  1  active-low chip select to the bank address decoder.
REQ-011 Port: oWrn  output  1  active-low write enable to the bank address decoder.
REQ-012 Port: oAddr  output  ADDR_W  flat address; [5:4] selects bank, [3:0] selects word.
REQ-013 Port: oWrDt  output  DATA_W  write data accompanying oCsn/oWrn.
REQ-014 Port: oBusy  output  1  high from accepted start until the cycle oDone is asserted, inclusive.
REQ-015 Port: oDone  output  1  one-cycle completion pulse.

Function
REQ-016 FSM states SHALL be IDLE, WAIT, WRITE, DONE; all outputs SHALL be registered.
REQ-017 IDLE: iStart=1 SHALL latch count N = min(iNumCoeff, 64), clear the address counter to 0, and go to WAIT; if N=0, go directly to DONE.
REQ-018 iStart SHALL be ignored in every state except IDLE.
REQ-019 WAIT: oCoeffReady=1; handshake occurs when iCoeffValid=1 and oCoeffReady=1; iCoeff SHALL be captured into oWrDt, and the FSM SHALL go to WRITE.
REQ-020 WRITE: oCsn=0 and oWrn=0 for exactly one cycle, with oAddr and oWrDt stable; oCoeffReady=0.
REQ-021 After WRITE: increment the address; if the written address was N-1, go to DONE, otherwise go to WAIT.
REQ-022 Throughput SHALL be one coefficient per 2 cycles at most; latency from handshake to write strobe SHALL be 1 cycle.
REQ-023 DONE: oDone=1 for one cycle, then go to IDLE; oAddr SHALL hold its last value until the next start.
REQ-024 Addresses SHALL be written strictly ascending from 0; the counter SHALL never wrap (maximum 63).
REQ-025 Outside WRITE, oCsn=1 and oWrn=1 at all times; oCsn and oWrn SHALL always be equal.
REQ-026 iCoeffValid outside WAIT SHALL be ignored and no data dropped: upstream holds valid until the handshake.

Reset
REQ-027 On iRsn=0 at a clock edge: state=IDLE, oCsn=1, oWrn=1, oAddr=0, oWrDt=0, oCoeffReady=0, oBusy=0, oDone=0, count=0.
REQ-028 Reset mid-sequence SHALL abort without a write strobe in the following cycle; partially written banks SHALL retain their data.
REQ-029 Reset SHALL dominate iStart in the same cycle.

Structure
REQ-030 A shared package SHALL hold DATA_W, ADDR_W, MAX_COEFF=64, and the FSM state encoding (2-bit).
REQ-031 No sub-module is required; the address counter and FSM reside in coeff_load_ctrl, and outputs connect directly to the existing bank address decoder.

Verification
REQ-032 Reset then iStart with iNumCoeff=4 and coefficients 0x0001..0x0004 with valid held high -> writes at addresses 0..3 with matching data, each strobe 1 cycle wide 2 cycles apart, oDone 1 cycle after the last strobe.
REQ-033 iNumCoeff=64 with a ramp 0..63 -> 64 strobes, address 15->16 crossing into bank 2 (oAddr[5:4]=01), last write at address 63, no wrap.
REQ-034 iNumCoeff=100 -> exactly 64 writes; iNumCoeff=0 -> no strobe, oDone in the cycle after start.
REQ-035 Valid toggling randomly (gaps of 0-5 cycles) with N=8 -> no lost or duplicated data, oCsn never low while oCoeffReady=1.
REQ-036 iStart pulsed during WAIT at address 2 -> ignored, sequence continues unchanged.
REQ-037 iRsn=0 asserted while in WRITE at address 5 -> next cycle oCsn=oWrn=1, oBusy=0, oAddr=0; a new start restarts from address 0.
